servo_motion_smoother: RTL and testbench

//  Slew-rate limiter between the memory/accelerometer source mux and pwm_servos.

---
 rtl/robotic_arm_pkg.sv | 23 ++
 rtl/axis_slew_limiter.sv | 99 +++++++++
 rtl/servo_motion_smoother.sv | 151 +++++++++++++++
 tb/tb_servo_motion_smoother.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robotic_arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : robotic_arm_pkg
// Description : Shared constants and the FSM state encoding for the servo
//               motion smoother.
//               AXIS_WIDTH - width of each unsigned X/Y/Z coordinate
//               RESET_POS  - position/target value after reset, all axes
//               smoother_state_t - IDLE / TRACK / HOLD
// Revision    : 1.0 - initial release
// ============================================================================
package robotic_arm_pkg;

    localparam int AXIS_WIDTH = 10;
    localparam int RESET_POS  = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } smoother_state_t;

endpackage : robotic_arm_pkg
`default_nettype wire

// File: rtl/axis_slew_limiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_slew_limiter
// Description : One axis of the motion smoother. Latches the axis target and
//               moves the registered position toward it by at most MAX_STEP
//               counts each time step_en is asserted.
//               Optional feature macro: SMOOTH_DEADBAND_EN - when defined, a
//               new target is latched only if it differs from the currently
//               latched target by more than DEADBAND counts.
// Ports       : clk          in  system clock
//               rst          in  synchronous reset, active-high
//               target       in  new target coordinate
//               target_valid in  latch target on this cycle
//               step_en      in  apply one slew step on this cycle
//               pos          out registered smoothed position
//               axis_done    out position equals latched target
// Revision    : 1.0 - initial release
// ============================================================================
module axis_slew_limiter
    import robotic_arm_pkg::*;
#(
    parameter int AXIS_WIDTH = robotic_arm_pkg::AXIS_WIDTH,
    parameter int MAX_STEP   = 4,
    parameter int RESET_POS  = robotic_arm_pkg::RESET_POS,
    parameter int DEADBAND   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXIS_WIDTH-1:0] target,
    input  logic                  target_valid,
    input  logic                  step_en,
    output logic [AXIS_WIDTH-1:0] pos,
    output logic                  axis_done
);

    localparam logic [AXIS_WIDTH-1:0] c_reset_pos = AXIS_WIDTH'(RESET_POS);
    localparam logic [AXIS_WIDTH-1:0] c_step      = AXIS_WIDTH'(MAX_STEP);
    localparam logic [AXIS_WIDTH:0]   c_step_w    = (AXIS_WIDTH+1)'(MAX_STEP);
    localparam logic [AXIS_WIDTH:0]   c_deadband  = (AXIS_WIDTH+1)'(DEADBAND);

`ifdef SMOOTH_DEADBAND_EN
    localparam logic c_deadband_en = 1'b1;
`else
    localparam logic c_deadband_en = 1'b0;
`endif

    logic [AXIS_WIDTH-1:0]   r_target;
    logic [AXIS_WIDTH-1:0]   r_pos;

    logic signed [AXIS_WIDTH:0] w_diff;      // target - pos
    logic [AXIS_WIDTH:0]        w_dist;      // |target - pos|
    logic signed [AXIS_WIDTH:0] w_tdiff;     // new target - latched target
    logic [AXIS_WIDTH:0]        w_tdist;     // |new target - latched target|
    logic                       w_latch;
    logic [AXIS_WIDTH-1:0]      w_pos_next;

    // One extra bit keeps the difference of two unsigned coordinates exact.
    assign w_diff  = $signed({1'b0, r_target}) - $signed({1'b0, r_pos});
    assign w_dist  = w_diff[AXIS_WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_tdiff = $signed({1'b0, target}) - $signed({1'b0, r_target});
    assign w_tdist = w_tdiff[AXIS_WIDTH] ? $unsigned(-w_tdiff) : $unsigned(w_tdiff);

    // With the deadband disabled every target_valid latches.
    assign w_latch = target_valid && (!c_deadband_en || (w_tdist > c_deadband));

    // A full step is only taken when the distance exceeds MAX_STEP, so the
    // position can neither overshoot nor wrap past either end of the range.
    always_comb begin
        w_pos_next = r_target;
        if (w_dist > c_step_w) begin
            if (w_diff[AXIS_WIDTH]) begin
                w_pos_next = r_pos - c_step;
            end else begin
                w_pos_next = r_pos + c_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= c_reset_pos;
            r_pos    <= c_reset_pos;
        end else begin
            // The step uses the previously latched target when both happen
            // in the same cycle; the new target applies from the next step.
            if (w_latch) begin
                r_target <= target;
            end
            if (step_en) begin
                r_pos <= w_pos_next;
            end
        end
    end

    assign pos       = r_pos;
    assign axis_done = (r_pos == r_target);

endmodule : axis_slew_limiter
`default_nettype wire

// File: rtl/servo_motion_smoother.sv
`default_nettype none
// ============================================================================
// Module      : servo_motion_smoother
// Description : Slew-rate limiter between the target source mux and the servo
//               PWM. Latches X/Y/Z targets and ramps the registered positions
//               toward them by at most MAX_STEP counts per update tick.
//               Optional feature macro: SMOOTH_DEADBAND_EN (per-axis target
//               deadband of DEADBAND counts, implemented in axis_slew_limiter).
// Ports       : clk          in  system clock
//               rst          in  synchronous reset, active-high
//               x/y/z_target in  target coordinates
//               target_valid in  latch targets this cycle
//               hold         in  freeze positions (level)
//               x/y/z_out    out smoothed positions, registered
//               busy         out FSM is in TRACK
//               at_target    out all positions equal latched targets
//               update_tick  out one-cycle pulse per update tick
// Revision    : 1.0 - initial release
// ============================================================================
module servo_motion_smoother
    import robotic_arm_pkg::*;
#(
    parameter int AXIS_WIDTH  = robotic_arm_pkg::AXIS_WIDTH,
    parameter int CLK_FREQ    = 50_000_000,
    parameter int UPDATE_FREQ = 1_000,
    parameter int MAX_STEP    = 4,
    parameter int RESET_POS   = robotic_arm_pkg::RESET_POS,
    parameter int DEADBAND    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXIS_WIDTH-1:0] x_target,
    input  logic [AXIS_WIDTH-1:0] y_target,
    input  logic [AXIS_WIDTH-1:0] z_target,
    input  logic                  target_valid,
    input  logic                  hold,
    output logic [AXIS_WIDTH-1:0] x_out,
    output logic [AXIS_WIDTH-1:0] y_out,
    output logic [AXIS_WIDTH-1:0] z_out,
    output logic                  busy,
    output logic                  at_target,
    output logic                  update_tick
);

    localparam int c_tick_div = CLK_FREQ / UPDATE_FREQ;
    localparam int c_cnt_w    = (c_tick_div > 1) ? $clog2(c_tick_div) : 1;
    localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(c_tick_div - 1);

    logic [c_cnt_w-1:0]    r_count;
    smoother_state_t       r_state;
    logic                  r_busy;
    logic                  r_at_target;

    logic                  w_tick;
    logic                  w_step_en;
    logic                  w_all_done;
    logic [2:0]            w_done;
    logic [AXIS_WIDTH-1:0] w_target [3];
    logic [AXIS_WIDTH-1:0] w_pos    [3];

    assign w_tick     = (r_count == c_tick_last);
    // hold wins over a coincident tick so positions never move while held.
    assign w_step_en  = w_tick && (r_state == ST_TRACK) && !hold;
    assign w_all_done = &w_done;

    assign w_target[0] = x_target;
    assign w_target[1] = y_target;
    assign w_target[2] = z_target;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_axis
            axis_slew_limiter #(
                .AXIS_WIDTH (AXIS_WIDTH),
                .MAX_STEP   (MAX_STEP),
                .RESET_POS  (RESET_POS),
                .DEADBAND   (DEADBAND)
            ) u_axis (
                .clk          (clk),
                .rst          (rst),
                .target       (w_target[g]),
                .target_valid (target_valid),
                .step_en      (w_step_en),
                .pos          (w_pos[g]),
                .axis_done    (w_done[g])
            );
        end
    endgenerate

    // Tick counter runs freely, including while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Control FSM; busy is registered alongside the state it mirrors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_at_target <= 1'b1;
        end else begin
            r_at_target <= w_all_done;
            if (hold) begin
                r_state <= ST_HOLD;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_all_done) begin
                            r_state <= ST_TRACK;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_TRACK: begin
                        if (w_all_done) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        if (w_all_done) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_TRACK;
                            r_busy  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign x_out       = w_pos[0];
    assign y_out       = w_pos[1];
    assign z_out       = w_pos[2];
    assign busy        = r_busy;
    assign at_target   = r_at_target;
    assign update_tick = w_tick;

endmodule : servo_motion_smoother
`default_nettype wire

// File: tb/tb_servo_motion_smoother.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_servo_motion_smoother
// Description : Self-checking bench for servo_motion_smoother with a tick
//               every 10 clocks and MAX_STEP = 4. Honours SMOOTH_DEADBAND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_motion_smoother;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x_target = 10'd512;
    logic [9:0] y_target = 10'd512;
    logic [9:0] z_target = 10'd512;
    logic       target_valid = 1'b0;
    logic       hold = 1'b0;
    logic [9:0] x_out, y_out, z_out;
    logic       busy, at_target, update_tick;

    servo_motion_smoother #(
        .AXIS_WIDTH  (10),
        .CLK_FREQ    (100),
        .UPDATE_FREQ (10),
        .MAX_STEP    (4),
        .RESET_POS   (512),
        .DEADBAND    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .x_target     (x_target),
        .y_target     (y_target),
        .z_target     (z_target),
        .target_valid (target_valid),
        .hold         (hold),
        .x_out        (x_out),
        .y_out        (y_out),
        .z_out        (z_out),
        .busy         (busy),
        .at_target    (at_target),
        .update_tick  (update_tick)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Behavioural model of the smoother; positions produced by each step
    // are pushed to exp_q and popped when the DUT outputs are sampled.
    int          m_cnt;
    int          m_pos [3];
    int          m_tgt [3];
    int          m_state;          // 0 idle, 1 track, 2 hold
    bit          m_at;
    bit          m_step;
    logic [29:0] exp_q [$];

    always @(posedge clk) begin
        int  nt [3];
        int  d;
        bit  tick;
        bit  eq;
        cyc++;
        if (rst) begin
            m_cnt   = 0;
            m_state = 0;
            m_at    = 1'b1;
            m_step  = 1'b0;
            for (int a = 0; a < 3; a++) begin
                m_pos[a] = 512;
                m_tgt[a] = 512;
            end
            exp_q.delete();
        end else begin
            tick = (m_cnt == 9);
            eq   = 1'b1;
            for (int a = 0; a < 3; a++) if (m_pos[a] != m_tgt[a]) eq = 1'b0;
            m_step = tick && (m_state == 1) && !hold;
            nt[0] = int'(x_target);
            nt[1] = int'(y_target);
            nt[2] = int'(z_target);
            for (int a = 0; a < 3; a++) begin
                if (m_step) begin
                    d = m_tgt[a] - m_pos[a];
                    if (d > 4)       m_pos[a] = m_pos[a] + 4;
                    else if (d < -4) m_pos[a] = m_pos[a] - 4;
                    else             m_pos[a] = m_tgt[a];
                end
                if (target_valid) begin
`ifdef SMOOTH_DEADBAND_EN
                    d = nt[a] - m_tgt[a];
                    if (d > 3 || d < -3) m_tgt[a] = nt[a];
`else
                    m_tgt[a] = nt[a];
`endif
                end
            end
            m_at = eq;
            if (hold)                 m_state = 2;
            else if (m_state == 0)    m_state = eq ? 0 : 1;
            else if (m_state == 1)    m_state = eq ? 0 : 1;
            else                      m_state = eq ? 0 : 1;
            m_cnt = tick ? 0 : m_cnt + 1;
            if (m_step) exp_q.push_back({m_pos[0][9:0], m_pos[1][9:0], m_pos[2][9:0]});
        end
    end

    always @(negedge clk) begin
        logic [29:0] e;
        if (chk_en) begin
            check("update_tick", update_tick, (m_cnt == 9));
            check("busy",        busy,        (m_state == 1));
            check("at_target",   at_target,   m_at);
            check("x_out",       x_out,       m_pos[0]);
            check("y_out",       y_out,       m_pos[1]);
            check("z_out",       z_out,       m_pos[2]);
            if (m_step) begin
                check("sb_avail", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_xyz", {x_out, y_out, z_out}, e);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [9:0] dut_pos(input int a);
        case (a)
            0:       return x_out;
            1:       return y_out;
            default: return z_out;
        endcase
    endfunction

    task automatic wait_change(input int a, input int budget, output logic [9:0] val, output bit ok);
        logic [9:0] prev;
        prev = dut_pos(a);
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut_pos(a) !== prev) begin
                ok = 1'b1;
                break;
            end
        end
        val = dut_pos(a);
        if (!ok) check("wait_change_timeout", ok, 1);
    endtask

    task automatic pulse_target(input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
        @(negedge clk);
        x_target     = x;
        y_target     = y;
        z_target     = z;
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [9:0] v;
        logic [9:0] prev;
        logic [9:0] frozen;
        logic [9:0] p;
        bit         ok;
        int         steps;
        int         t1;
        int         t2;

        // 1. reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_x", x_out, 512);
        check("rst_y", y_out, 512);
        check("rst_z", z_out, 512);
        check("rst_at_target", at_target, 1);
        check("rst_busy", busy, 0);
        check("rst_tick", update_tick, 0);
        rst = 1'b0;

        t1 = 0;
        for (int i = 0; i < 25 && !update_tick; i++) @(negedge clk);
        check("tick_seen", update_tick, 1);
        t1 = cyc;
        @(negedge clk);
        for (int i = 0; i < 25 && !update_tick; i++) @(negedge clk);
        t2 = cyc;
        check("tick_period", t2 - t1, 10);

        // 2. ramp x 512 -> 600
        pulse_target(10'd600, 10'd512, 10'd512);
        prev  = x_out;
        steps = 0;
        for (int i = 0; i < 30 && x_out != 10'd600; i++) begin
            wait_change(0, 30, v, ok);
            if (!ok) break;
            check("ramp_step", v, prev + 10'd4);
            prev = v;
            steps++;
        end
        check("ramp_ticks", steps, 22);
        @(negedge clk);
        check("ramp_busy_done", busy, 0);
        check("ramp_at_target", at_target, 1);

        // 3. partial final step on z, long descent on y without wrap
        pulse_target(10'd600, 10'd0, 10'd514);
        wait_change(2, 30, v, ok);
        check("z_partial", v, 514);
        steps = (y_out != 10'd512) ? 1 : 0;
        prev  = y_out;
        for (int i = 0; i < 200 && y_out != 10'd0; i++) begin
            wait_change(1, 30, v, ok);
            if (!ok) break;
            check("y_step", v, prev - 10'd4);
            prev = v;
            steps++;
        end
        check("y_ticks", steps, 128);
        repeat (30) @(negedge clk);
        check("y_no_wrap", y_out, 0);
        check("z_no_overshoot", z_out, 514);

        // 4. hold mid-ramp, release, then target on a tick cycle
        pulse_target(10'd700, 10'd0, 10'd514);
        for (int i = 0; i < 3; i++) wait_change(0, 30, v, ok);
        @(negedge clk);
        hold   = 1'b1;
        frozen = x_out;
        repeat (35) @(negedge clk);
        check("hold_frozen", x_out, frozen);
        check("hold_busy", busy, 0);
        hold = 1'b0;
        wait_change(0, 30, v, ok);
        check("hold_resume", v, frozen + 10'd4);

        for (int i = 0; i < 25 && !update_tick; i++) @(negedge clk);
        check("collide_tick_seen", update_tick, 1);
        p            = x_out;
        x_target     = p + 10'd2;
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
        check("collide_old_tgt", x_out, p + 10'd4);
        wait_change(0, 30, v, ok);
        check("collide_new_tgt", v, p + 10'd2);

        // 5. reset mid-ramp
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_target(10'd600, 10'd512, 10'd512);
        for (int i = 0; i < 20 && x_out != 10'd560; i++) begin
            wait_change(0, 30, v, ok);
            if (!ok) break;
        end
        check("pre_reset_x", x_out, 560);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_x", x_out, 512);
        check("midrst_busy", busy, 0);
        check("midrst_at_target", at_target, 1);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_discard", x_out, 512);

        // 6. deadband (or plain latch when the deadband is not built in)
`ifdef SMOOTH_DEADBAND_EN
        pulse_target(10'd514, 10'd512, 10'd512);
        repeat (30) @(negedge clk);
        check("db_ignored", x_out, 512);
        check("db_at_target", at_target, 1);
        pulse_target(10'd516, 10'd512, 10'd512);
        wait_change(0, 30, v, ok);
        check("db_latched", v, 516);
`else
        pulse_target(10'd514, 10'd512, 10'd512);
        wait_change(0, 30, v, ok);
        check("small_latched", v, 514);
`endif

        repeat (5) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_servo_motion_smoother
`default_nettype wire
